// File: rtl/sub12u_pkg.sv
// Shared widths, operand/result types and reference arithmetic for the approximate 12-bit subtractor.
// Error statistics are compiled in only when SUB12U_ERRSTAT_EN is defined.
package sub12u_pkg;

  localparam int W     = 12;
  localparam int K     = 8;
  localparam int CNT_W = 16;

  typedef logic [W-1:0] opnd_t;
  typedef logic [W:0]   res_t;   // {borrow, d}
  typedef logic [W-K:0] hi_t;    // {borrow, d[W-1:K]}

  function automatic res_t exact_sub(opnd_t a, opnd_t b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  function automatic res_t abs_diff(res_t x, res_t y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/sub12u_approx_core.sv
// Combinational approximate subtractor: low K bits pass the minuend through, upper bits are
// subtracted exactly using a borrow guessed from bit K-1 alone.
module sub12u_approx_core
  import sub12u_pkg::*;
(
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W:0]   res_o
);

  logic bor_est;
  hi_t  a_hi;
  hi_t  b_hi;
  hi_t  hi_diff;

  // Borrow out of the low field is certain only when b's top low bit is set and a's is clear.
  assign bor_est = b_i[K-1] & ~a_i[K-1];
  assign a_hi    = {1'b0, a_i[W-1:K]};
  assign b_hi    = {1'b0, b_i[W-1:K]};
  assign hi_diff = a_hi - b_hi - hi_t'(bor_est);
  assign res_o   = {hi_diff, a_i[K-1:0]};

endmodule

// File: rtl/sub12u_approx_pipe.sv
// Two-stage valid/ready pipeline around sub12u_approx_core (S1 = operands, S2 = result).
// Define SUB12U_ERRSTAT_EN to add err_max/err_cnt ports fed by a parallel exact subtractor.
module sub12u_approx_pipe
  import sub12u_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     d,
  output logic             borrow
`ifdef SUB12U_ERRSTAT_EN
  ,
  output logic [W:0]       err_max,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  logic  s1_valid_q, s1_valid_d;
  opnd_t s1_a_q, s1_a_d;
  opnd_t s1_b_q, s1_b_d;
  logic  s2_valid_q, s2_valid_d;
  res_t  s2_res_q, s2_res_d;
  res_t  core_res;
  logic  s1_adv;
  logic  out_fire;

  // Handshake: a side transfers on valid & ready. S2 may load whenever it is empty or being
  // drained (s1_adv); S1 may load when empty or moving into S2. out_valid is purely registered.
  assign s1_adv    = ~s2_valid_q | out_ready;
  assign in_ready  = ~s1_valid_q | s1_adv;
  assign out_valid = s2_valid_q;
  assign out_fire  = s2_valid_q & out_ready;
  assign d         = s2_res_q[W-1:0];
  assign borrow    = s2_res_q[W];

  sub12u_approx_core u_core (
    .a_i   (s1_a_q),
    .b_i   (s1_b_q),
    .res_o (core_res)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d = a;
        s1_b_d = b;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    if (s1_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_res_d = core_res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
    end
  end

`ifdef SUB12U_ERRSTAT_EN
  res_t             s1_exact_q, s1_exact_d;
  res_t             s2_exact_q, s2_exact_d;
  res_t             err_max_q, err_max_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  res_t             err_now;

  assign err_now = abs_diff(s2_res_q, s2_exact_q);
  assign err_max = err_max_q;
  assign err_cnt = err_cnt_q;

  // The exact result travels alongside the approximate one so both leave S2 together.
  always_comb begin
    s1_exact_d = s1_exact_q;
    s2_exact_d = s2_exact_q;
    if (in_ready && in_valid) begin
      s1_exact_d = exact_sub(a, b);
    end
    if (s1_adv && s1_valid_q) begin
      s2_exact_d = s1_exact_q;
    end
  end

  always_comb begin
    err_max_d = err_max_q;
    err_cnt_d = err_cnt_q;
    if (out_fire) begin
      if (err_now > err_max_q) begin
        err_max_d = err_now;
      end
      if ((err_now != '0) && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_exact_q <= '0;
      s2_exact_q <= '0;
      err_max_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      s1_exact_q <= s1_exact_d;
      s2_exact_q <= s2_exact_d;
      err_max_q  <= err_max_d;
      err_cnt_q  <= err_cnt_d;
    end
  end
`else
  logic unused_fire;
  assign unused_fire = out_fire;
`endif

endmodule

// File: tb/tb_sub12u_approx_pipe.sv
// Directed bench for sub12u_approx_pipe: hand-computed vectors, back-pressure, random stream, reset.
// Stats checks are compiled when SUB12U_ERRSTAT_EN is defined.
module tb_sub12u_approx_pipe;
  import sub12u_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] a;
  logic [11:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] d;
  logic        borrow;
`ifdef SUB12U_ERRSTAT_EN
  logic [12:0] err_max;
  logic [15:0] err_cnt;
  logic [12:0] err_q[$];
  logic [12:0] exp_err_max;
  logic [15:0] exp_err_cnt;
`endif

  logic [11:0] model_a;
  logic [11:0] model_b;
  logic [12:0] model_res;
  logic [12:0] exp_q[$];
  int          n_checks;
  int          n_fail;
  int          tx_cnt;
  int          tx0;

  sub12u_approx_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .borrow    (borrow)
`ifdef SUB12U_ERRSTAT_EN
    ,
    .err_max   (err_max),
    .err_cnt   (err_cnt)
`endif
  );

  sub12u_approx_core u_model (
    .a_i   (model_a),
    .b_i   (model_b),
    .res_o (model_res)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] model_err(input logic [11:0] pa, input logic [11:0] pb,
                                            input logic [12:0] approx);
    logic [12:0] ex;
    ex = {1'b0, pa} - {1'b0, pb};
    return (approx >= ex) ? (approx - ex) : (ex - approx);
  endfunction

  // driver: present one pair, wait (bounded) for acceptance, record expectation
  task automatic push(input logic [11:0] pa, input logic [11:0] pb, input logic [12:0] pexp);
    int waited;
    waited   = 0;
    a        = pa;
    b        = pb;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    check("push_accept", in_ready, 1);
    if (in_ready) begin
      exp_q.push_back(pexp);
`ifdef SUB12U_ERRSTAT_EN
      err_q.push_back(model_err(pa, pb, pexp));
`endif
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // scoreboard: every output transfer must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      tx_cnt++;
      check("sb_nonempty", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check("sb_result", {borrow, d}, exp_q.pop_front());
`ifdef SUB12U_ERRSTAT_EN
        begin
          logic [12:0] e;
          e = err_q.pop_front();
          if (e > exp_err_max) exp_err_max = e;
          if (e != 0 && exp_err_cnt != 16'hFFFF) exp_err_cnt = exp_err_cnt + 16'd1;
        end
`endif
      end
    end
  end

  initial begin
    logic [12:0] r_exp;
    n_checks  = 0;
    n_fail    = 0;
    tx_cnt    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    model_a   = '0;
    model_b   = '0;
`ifdef SUB12U_ERRSTAT_EN
    exp_err_max = '0;
    exp_err_cnt = '0;
`endif

    // reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_d", d, 0);
    check("rst_borrow", borrow, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef SUB12U_ERRSTAT_EN
    check("rst_err_max", err_max, 0);
    check("rst_err_cnt", err_cnt, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: 0x100 - 0x001
    out_ready = 1'b1;
    push(12'h100, 12'h001, 13'h0100);
    @(negedge clk);
    check("t1_lat1_valid", out_valid, 0);
    @(negedge clk);
    check("t1_out_valid", out_valid, 1);
    check("t1_d", d, 12'h100);
    check("t1_borrow", borrow, 0);
    @(posedge clk);
    #1;
`ifdef SUB12U_ERRSTAT_EN
    check("t1_err_cnt", err_cnt, 1);
    check("t1_err_max", err_max, 1);
`endif

    // 2: 0x000 - 0x080
    push(12'h000, 12'h080, 13'h1F00);
    @(negedge clk);
    @(negedge clk);
    check("t2_out_valid", out_valid, 1);
    check("t2_d", d, 12'hF00);
    check("t2_borrow", borrow, 1);
    @(posedge clk);
    #1;
`ifdef SUB12U_ERRSTAT_EN
    check("t2_err_max", err_max, 13'h080);
    check("t2_err_cnt", err_cnt, 2);
`endif

    // 3: 0xFFF - 0x000
    push(12'hFFF, 12'h000, 13'h0FFF);
    @(negedge clk);
    @(negedge clk);
    check("t3_d", d, 12'hFFF);
    check("t3_borrow", borrow, 0);
    @(posedge clk);
    #1;
`ifdef SUB12U_ERRSTAT_EN
    check("t3_err_cnt", err_cnt, 2);
    check("t3_err_max", err_max, 13'h080);
`endif

    // 4: back-pressure with four pairs
    out_ready = 1'b0;
    tx0 = tx_cnt;
    push(12'h234, 12'h123, 13'h0134);
    push(12'h500, 12'h3C0, 13'h0100);
    a        = 12'h0FF;
    b        = 12'h1FF;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_in_ready_low", in_ready, 0);
      check("t4_out_valid", out_valid, 1);
      check("t4_d_frozen", {borrow, d}, 13'h0134);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(12'h0FF, 12'h1FF, 13'h1FFF);
    push(12'h800, 12'h800, 13'h0000);
    repeat (4) @(negedge clk);
    check("t4_drained", exp_q.size(), 0);
    check("t4_tx_count", tx_cnt - tx0, 4);
`ifdef SUB12U_ERRSTAT_EN
    check("t4_err_max", err_max, 13'h0FF);
    check("t4_err_cnt", err_cnt, 5);
`endif
    @(posedge clk);
    #1;

    // 5: continuous stream of 100 random pairs
    tx0 = tx_cnt;
    for (int i = 0; i < 100; i++) begin
      a        = 12'($urandom_range(0, 4095));
      b        = 12'($urandom_range(0, 4095));
      model_a  = a;
      model_b  = b;
      in_valid = 1'b1;
      #1;
      r_exp = model_res;
      @(negedge clk);
      check("t5_in_ready", in_ready, 1);
      if (in_ready) begin
        exp_q.push_back(r_exp);
`ifdef SUB12U_ERRSTAT_EN
        err_q.push_back(model_err(a, b, r_exp));
`endif
      end
      if (i >= 2) check("t5_out_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_tx_count", tx_cnt - tx0, 100);
    check("t5_drained", exp_q.size(), 0);
`ifdef SUB12U_ERRSTAT_EN
    check("t5_err_max", err_max, exp_err_max);
    check("t5_err_cnt", err_cnt, exp_err_cnt);
`endif
    @(posedge clk);
    #1;

    // 6: reset with two items in flight
    out_ready = 1'b0;
    push(12'h321, 12'h0F0, 13'h0221);
    push(12'h777, 12'h111, 13'h0677);
    rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_d", d, 0);
    check("t6_rst_borrow", borrow, 0);
    check("t6_rst_in_ready", in_ready, 1);
`ifdef SUB12U_ERRSTAT_EN
    check("t6_rst_err_max", err_max, 0);
    check("t6_rst_err_cnt", err_cnt, 0);
    err_q.delete();
    exp_err_max = '0;
    exp_err_cnt = '0;
`endif
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(12'hABC, 12'h123, 13'h09BC);
    @(negedge clk);
    check("t6_lat1_valid", out_valid, 0);
    @(negedge clk);
    check("t6_out_valid", out_valid, 1);
    check("t6_d", d, 12'h9BC);
    check("t6_borrow", borrow, 0);
    @(posedge clk);
    #1;
`ifdef SUB12U_ERRSTAT_EN
    check("t6_err_cnt", err_cnt, 1);
    check("t6_err_max", err_max, 13'h023);
`endif
    @(negedge clk);
    check("t6_drained", exp_q.size(), 0);
    check("t6_idle", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
